// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED blink controller.
//   mode_e     : command mode encoding (off / solid / blink / burst)
//   state_e    : controller FSM states
//   PERIOD_W   : width of the half-period / phase counter
//   COUNT_W    : width of the burst pulse counter
//   eff_period : maps a requested period of 0 onto 1
package led_ctrl_pkg;

  localparam int unsigned PERIOD_W = 8;
  localparam int unsigned COUNT_W  = 4;

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModeBurst = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSolid    = 3'd1,
    StBlinkOn  = 3'd2,
    StBlinkOff = 3'd3,
    StBurstOn  = 3'd4,
    StBurstOff = 3'd5
  } state_e;

  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? PERIOD_W'(1) : p;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Timebase prescaler: emits a one-cycle tick every TICK_DIV clk cycles.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, restarts the prescaler from zero
//   tick  : one-cycle pulse on the last cycle of each TICK_DIV window
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// LED controller: off, solid, continuous blink, or a finite burst of blinks.
//   clk, rst_n  : clock and asynchronous active-low reset
//   cmd_valid   : command present; accepted when cmd_ready is also high
//   cmd_ready   : low only while a burst runs (bursts are never preempted)
//   cmd_mode    : 0 off, 1 on, 2 blink, 3 burst
//   cmd_period  : half-period in timebase ticks (0 treated as 1)
//   cmd_count   : number of on-pulses for a burst
//   busy        : high while a burst is in progress
//   done        : one-cycle pulse when a burst completes
//   led         : registered LED drive, 1 = lit
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [COUNT_W-1:0]  cmd_count,
  output logic                busy,
  output logic                done,
  output logic                led
);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [COUNT_W-1:0]  rem_q, rem_d;
  logic                led_q, led_d;
  logic                done_q, done_d;

  logic accept;
  logic tick;
  logic timed;
  logic phase_end;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .tick  (tick)
  );

  assign busy      = (state_q == StBurstOn) || (state_q == StBurstOff);
  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;
  assign done      = done_q;
  assign led       = led_q;

  // Only the blinking states consume ticks; period_q >= 1 whenever they are active.
  assign timed     = (state_q == StBlinkOn) || (state_q == StBlinkOff) || busy;
  assign phase_end = tick && (phase_q == (period_q - PERIOD_W'(1)));

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    phase_d  = phase_q;
    rem_d    = rem_q;
    done_d   = 1'b0;

    if (accept) begin
      // A new command wins over any phase expiry in the same cycle.
      period_d = eff_period(cmd_period);
      phase_d  = '0;
      rem_d    = '0;
      case (mode_e'(cmd_mode))
        ModeOff:   state_d = StIdle;
        ModeOn:    state_d = StSolid;
        ModeBlink: state_d = StBlinkOn;
        ModeBurst: begin
          if (cmd_count == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StBurstOn;
            rem_d   = cmd_count;
          end
        end
        default:   state_d = StIdle;
      endcase
    end else if (timed && tick) begin
      if (phase_end) begin
        phase_d = '0;
        case (state_q)
          StBlinkOn:  state_d = StBlinkOff;
          StBlinkOff: state_d = StBlinkOn;
          StBurstOn:  state_d = StBurstOff;
          StBurstOff: begin
            if (rem_q <= COUNT_W'(1)) begin
              rem_d   = '0;
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              rem_d   = rem_q - COUNT_W'(1);
              state_d = StBurstOn;
            end
          end
          default:    state_d = state_q;
        endcase
      end else begin
        phase_d = phase_q + PERIOD_W'(1);
      end
    end

    led_d = (state_d == StSolid) || (state_d == StBlinkOn) || (state_d == StBurstOn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      period_q <= '0;
      phase_q  <= '0;
      rem_q    <= '0;
      led_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      rem_q    <= rem_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed self-checking bench for led_blink_ctrl with TICK_DIV = 4.
module tb_led_blink_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_period;
  logic [3:0] cmd_count;
  logic       busy;
  logic       done;
  logic       led;

  int checks = 0;
  int errors = 0;

  led_blink_ctrl #(
    .TICK_DIV (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_period (cmd_period),
    .cmd_count  (cmd_count),
    .busy       (busy),
    .done       (done),
    .led        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one edge; returns in the first cycle after acceptance.
  task automatic accept(input logic [1:0] m, input logic [7:0] p, input logic [3:0] c);
    cmd_mode   = m;
    cmd_period = p;
    cmd_count  = c;
    cmd_valid  = 1'b1;
    check("ready_before_accept", cmd_ready, 1'b1);
    step();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_mode   = 2'd0;
    cmd_period = 8'd0;
    cmd_count  = 4'd0;

    // Reset state
    #2;
    check("rst_led", led, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("post_rst_led", led, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_done", done, 1'b0);
    check("post_rst_ready", cmd_ready, 1'b1);

    // Solid on, then off
    accept(2'd1, 8'd0, 4'd0);
    check("solid_led_c1", led, 1'b1);
    repeat (5) step();
    check("solid_led_hold", led, 1'b1);
    check("solid_busy", busy, 1'b0);
    accept(2'd0, 8'd5, 4'd0);
    check("off_led", led, 1'b0);

    // Blink, period 2: 8 cycles on, 8 off, first rise one cycle after acceptance
    accept(2'd2, 8'd2, 4'd0);
    for (int i = 1; i <= 17; i++) begin
      check("blink_p2_led", led, (((i - 1) / 8) % 2) == 0);
      check("blink_p2_ready", cmd_ready, 1'b1);
      step();
    end

    // Mid-phase preemption of blink by solid
    accept(2'd1, 8'd0, 4'd0);
    for (int i = 0; i < 12; i++) begin
      check("preempt_solid_led", led, 1'b1);
      step();
    end

    // Command accepted on the same edge a blink phase expires wins
    accept(2'd2, 8'd1, 4'd0);
    check("prec_blink_led", led, 1'b1);
    repeat (3) step();
    accept(2'd1, 8'd0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      check("prec_solid_led", led, 1'b1);
      step();
    end

    // Burst of 3, period 1, with a second burst held off until done
    accept(2'd3, 8'd1, 4'd3);
    cmd_mode   = 2'd3;
    cmd_period = 8'd1;
    cmd_count  = 4'd1;
    cmd_valid  = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      check("burst3_led", led, (i <= 24) && ((((i - 1) / 4) % 2) == 0));
      check("burst3_busy", busy, i <= 24);
      check("burst3_ready", cmd_ready, i == 25);
      check("burst3_done", done, i == 25);
      step();
    end
    cmd_valid = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      check("burst1_led", led, j <= 4);
      check("burst1_busy", busy, j <= 8);
      check("burst1_done", done, j == 9);
      step();
    end

    // Burst with count 0: immediate done, LED never lit
    accept(2'd3, 8'd1, 4'd0);
    check("burst0_done", done, 1'b1);
    check("burst0_led", led, 1'b0);
    check("burst0_busy", busy, 1'b0);
    check("burst0_ready", cmd_ready, 1'b1);
    step();
    check("burst0_done_once", done, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("burst0_led_dark", led, 1'b0);
      step();
    end

    // Period 0 behaves as period 1
    accept(2'd2, 8'd0, 4'd0);
    for (int i = 1; i <= 9; i++) begin
      check("blink_p0_led", led, (((i - 1) / 4) % 2) == 0);
      step();
    end

    // Reset asserted mid-burst aborts without done
    accept(2'd3, 8'd1, 4'd2);
    repeat (2) step();
    check("abort_pre_led", led, 1'b1);
    check("abort_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_led", led, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("abort_idle_done", done, 1'b0);
      check("abort_idle_led", led, 1'b0);
      check("abort_idle_ready", cmd_ready, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
